// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Instruction-memory request/response bus of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : RV32I fetch stage - PC register, single-outstanding fetch and
//               next-PC selection with sticky misaligned-target fault.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               instr,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [31:0]               pc_out,
    input  logic [31:0]               imm,
    input  logic [31:0]               rs1_val,
    input  logic                      branch_taken,
    input  logic                      jal,
    input  logic                      jalr,
    output logic                      fault,
    output logic [31:0]               fault_addr
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic        w_req_valid;
    logic        w_handshake;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_target;

    assign w_handshake = instr_valid_q && instr_ready;
    assign w_jalr_sum  = rs1_val + imm;

    // JALR wins over JAL/branch; bit 0 of the JALR target is architecturally cleared.
    assign w_target = jalr                ? (w_jalr_sum & ~32'h1) :
                      (jal | branch_taken) ? (pc_q + imm)          :
                                             (pc_q + 32'd4);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        fault_addr_d  = fault_addr_q;
        w_req_valid   = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                w_req_valid = 1'b1;
                if (imem.imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_resp_valid) begin
                    instr_d       = imem.imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_handshake) begin
                    instr_valid_d = 1'b0;
                    if (w_target[1:0] == 2'b00) begin
                        pc_d    = w_target;
                        state_d = ST_REQ;
                    end else begin
                        fault_d      = 1'b1;
                        fault_addr_d = w_target;
                        state_d      = ST_FAULT;
                    end
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            fault_addr_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_addr      = pc_q;
    assign instr               = instr_q;
    assign instr_valid         = instr_valid_q;
    assign pc_out              = pc_q;
    assign fault               = fault_q;
    assign fault_addr          = fault_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit with memory responder
//               and fetch scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] pc_out;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1_val = 32'h0;
    logic        branch_taken = 1'b0;
    logic        jal = 1'b0;
    logic        jalr = 1'b0;
    logic        fault;
    logic [31:0] fault_addr;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (bus),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_out       (pc_out),
        .imm          (imm),
        .rs1_val      (rs1_val),
        .branch_taken (branch_taken),
        .jal          (jal),
        .jalr         (jalr),
        .fault        (fault),
        .fault_addr   (fault_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

    sb_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mem_ready = 1'b1;
    bit          resp_pend = 1'b0;
    logic [31:0] resp_data = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    // Zero-wait memory: answers in the cycle after a request is accepted.
    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_rdata      = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_resp_valid = resp_pend;
            bus.imem_rdata      = resp_pend ? resp_data : 32'h0;
            resp_pend           = 1'b0;
            bus.imem_req_ready  = mem_ready;
            #1;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                resp_pend = 1'b1;
                resp_data = mem_word(bus.imem_addr);
                exp_q.push_back('{addr: bus.imem_addr, data: resp_data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.imem_req_valid) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_hold(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (instr_valid) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic sb_pop(output logic [31:0] ea, output logic [31:0] ed, output bit ok);
        sb_t e;
        ea = 32'h0;
        ed = 32'h0;
        ok = (exp_q.size() != 0);
        if (ok) begin
            e  = exp_q.pop_front();
            ea = e.addr;
            ed = e.data;
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        branch_taken = 1'b0;
        jal          = 1'b0;
        jalr         = 1'b0;
        imm          = 32'h0;
        rs1_val      = 32'h0;
        instr_ready  = 1'b1;
        mem_ready    = 1'b1;
        tick();
        tick();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        checks++;
        if (bus.imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_ctl: req_valid=%b instr_valid=%b instr=%h expected 0 0 0",
                     bus.imem_req_valid, instr_valid, instr);
        end
        checks++;
        if (fault !== 1'b0 || fault_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_fault: fault=%b fault_addr=%h expected 0 0", fault, fault_addr);
        end
        checks++;
        if (bus.imem_addr !== RESET_PC || pc_out !== RESET_PC) begin
            errors++;
            $display("FAIL reset_pc: addr=%h pc_out=%h expected %h", bus.imem_addr, pc_out, RESET_PC);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_first_req: req_valid=%b addr=%h expected 1 %h",
                     bus.imem_req_valid, bus.imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] ea, ed;
        int last_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            wait_req(ok);
            checks++;
            if (!ok || bus.imem_addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL seq_addr%0d: ok=%b addr=%h expected %h", k, ok, bus.imem_addr, 32'(4 * k));
            end
            wait_hold(ok);
            sb_pop(ea, ed, ok);
            checks++;
            if (!ok || instr !== ed || pc_out !== ea || pc_out !== 32'(4 * k)) begin
                errors++;
                $display("FAIL seq_data%0d: instr=%h pc_out=%h expected instr=%h pc=%h",
                         k, instr, pc_out, ed, 32'(4 * k));
            end
            if (k > 0) begin
                checks++;
                if (cyc - last_cyc != 3) begin
                    errors++;
                    $display("FAIL seq_rate%0d: %0d cycles between instructions expected 3",
                             k, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            tick();
        end
    endtask

    task automatic test_req_stall();
        bit ok;
        logic [31:0] ea, ed;
        mem_ready = 1'b0;
        do_reset();
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_req%0d: req_valid=%b addr=%h instr_valid=%b expected 1 0 0",
                         i, bus.imem_req_valid, bus.imem_addr, instr_valid);
            end
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept: req_valid=%b ready=%b expected 1 1",
                     bus.imem_req_valid, bus.imem_req_ready);
        end
        tick();
        checks++;
        if (bus.imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_wait: req_valid=%b instr_valid=%b expected 0 0",
                     bus.imem_req_valid, instr_valid);
        end
        wait_hold(ok);
        sb_pop(ea, ed, ok);
        checks++;
        if (!ok || instr !== ed || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL stall_data: instr=%h pc_out=%h expected %h 0", instr, pc_out, ed);
        end
    endtask

    task automatic test_hold_redirect();
        bit ok;
        logic [31:0] ea, ed, held;
        do_reset();
        wait_hold(ok);
        sb_pop(ea, ed, ok);
        branch_taken = 1'b1;
        imm          = 32'h10;
        tick();
        branch_taken = 1'b0;
        imm          = 32'h0;
        wait_req(ok);
        checks++;
        if (!ok || bus.imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL br_fwd: ok=%b addr=%h expected 10", ok, bus.imem_addr);
        end
        wait_hold(ok);
        sb_pop(ea, ed, ok);
        checks++;
        if (!ok || instr !== ed || pc_out !== 32'h10) begin
            errors++;
            $display("FAIL hold_data: instr=%h pc_out=%h expected %h 10", instr, pc_out, ed);
        end
        instr_ready = 1'b0;
        held        = instr;
        for (int i = 0; i < 5; i++) begin
            imm          = $urandom;
            rs1_val      = $urandom;
            branch_taken = 1'($urandom_range(0, 1));
            jal          = 1'($urandom_range(0, 1));
            jalr         = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr !== held || bus.imem_req_valid !== 1'b0 || pc_out !== 32'h10) begin
                errors++;
                $display("FAIL hold_stable%0d: valid=%b instr=%h req=%b pc=%h expected 1 %h 0 10",
                         i, instr_valid, instr, bus.imem_req_valid, pc_out, held);
            end
        end
        branch_taken = 1'b1;
        jal          = 1'b0;
        jalr         = 1'b0;
        imm          = 32'hFFFF_FFF8;
        instr_ready  = 1'b1;
        tick();
        branch_taken = 1'b0;
        imm          = 32'h0;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_back: req=%b addr=%h instr_valid=%b expected 1 8 0",
                     bus.imem_req_valid, bus.imem_addr, instr_valid);
        end
    endtask

    task automatic test_jalr_fault();
        bit ok;
        logic [31:0] ea, ed;
        do_reset();
        wait_hold(ok);
        sb_pop(ea, ed, ok);
        jal = 1'b1;
        imm = 32'h20;
        tick();
        jal = 1'b0;
        imm = 32'h0;
        wait_hold(ok);
        sb_pop(ea, ed, ok);
        checks++;
        if (!ok || pc_out !== 32'h20 || instr !== ed) begin
            errors++;
            $display("FAIL jal_fwd: pc_out=%h instr=%h expected 20 %h", pc_out, instr, ed);
        end
        jalr    = 1'b1;
        rs1_val = 32'h1001;
        imm     = 32'h4;
        tick();
        jalr    = 1'b0;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h1004 || fault !== 1'b0) begin
            errors++;
            $display("FAIL jalr_ok: req=%b addr=%h fault=%b expected 1 1004 0",
                     bus.imem_req_valid, bus.imem_addr, fault);
        end
        wait_hold(ok);
        sb_pop(ea, ed, ok);
        jalr    = 1'b1;
        rs1_val = 32'h1002;
        imm     = 32'h0;
        tick();
        jalr    = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_addr !== 32'h1002 || pc_out !== 32'h1004 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL jalr_fault: fault=%b fault_addr=%h pc=%h valid=%b expected 1 1002 1004 0",
                     fault, fault_addr, pc_out, instr_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.imem_req_valid !== 1'b0 || fault !== 1'b1 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL fault_sticky%0d: req=%b fault=%b valid=%b expected 0 1 0",
                         i, bus.imem_req_valid, fault, instr_valid);
            end
        end
        do_reset();
        checks++;
        if (fault !== 1'b0 || fault_addr !== 32'h0) begin
            errors++;
            $display("FAIL fault_clear: fault=%b fault_addr=%h expected 0 0", fault, fault_addr);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] ea, ed;
        do_reset();
        wait_hold(ok);
        sb_pop(ea, ed, ok);
        jal = 1'b1;
        imm = 32'hFFFF_FFFC;
        tick();
        jal = 1'b0;
        imm = 32'h0;
        wait_hold(ok);
        sb_pop(ea, ed, ok);
        checks++;
        if (!ok || pc_out !== 32'hFFFF_FFFC || instr !== ed) begin
            errors++;
            $display("FAIL wrap_top: pc_out=%h instr=%h expected fffffffc %h", pc_out, instr, ed);
        end
        tick();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL wrap_zero: req=%b addr=%h fault=%b expected 1 0 0",
                     bus.imem_req_valid, bus.imem_addr, fault);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] ea, ed;
        do_reset();
        wait_hold(ok);
        sb_pop(ea, ed, ok);
        jal = 1'b1;
        imm = 32'h40;
        tick();
        jal = 1'b0;
        imm = 32'h0;
        wait_req(ok);
        tick();
        checks++;
        if (bus.imem_resp_valid !== 1'b1 || bus.imem_req_valid !== 1'b0 || pc_out !== 32'h40) begin
            errors++;
            $display("FAIL mid_wait: resp=%b req=%b pc=%h expected 1 0 40",
                     bus.imem_resp_valid, bus.imem_req_valid, pc_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc_out !== RESET_PC || bus.imem_addr !== RESET_PC || instr_valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL mid_async: pc=%h addr=%h valid=%b instr=%h expected 0 0 0 0",
                     pc_out, bus.imem_addr, instr_valid, instr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_drop: valid=%b instr=%h req=%b expected 0 0 0",
                     instr_valid, instr, bus.imem_req_valid);
        end
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        wait_req(ok);
        checks++;
        if (!ok || bus.imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL mid_restart: ok=%b addr=%h expected %h", ok, bus.imem_addr, RESET_PC);
        end
        wait_hold(ok);
        sb_pop(ea, ed, ok);
        checks++;
        if (!ok || instr !== mem_word(RESET_PC) || pc_out !== RESET_PC) begin
            errors++;
            $display("FAIL mid_refetch: instr=%h pc=%h expected %h %h",
                     instr, pc_out, mem_word(RESET_PC), RESET_PC);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_req_stall();
        test_hold_redirect();
        test_jalr_fault();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
